fifo_ctrl: RTL

//  Single-clock FIFO controller that sequences the mem_fifo RAM: owns write/read pointers,

---
 rtl/fifo_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock FIFO controller for the mem_fifo RAM.
// Owns the read/write pointers, occupancy count and status flags.
// Also drives the RAM write and read strobes and their addresses.
// Data never passes through this block. The RAM returns the popped word
// one cycle later, and rvalid marks that cycle.
module fifo_ctrl #(
  parameter int mem_size = 4,
  parameter int AF_LVL   = 14,
  parameter int AE_LVL   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic                err_clr,
  output logic                mem_we,
  output logic [mem_size-1:0] mem_we_point,
  output logic                mem_re,
  output logic [mem_size-1:0] mem_re_point,
  output logic                rvalid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [mem_size:0]   count,
  output logic                overflow,
  output logic                underflow
);

  // Occupancy thresholds, sized to the count register.
  localparam logic [mem_size:0] DEPTH_V = {1'b1, {mem_size{1'b0}}};
  localparam logic [mem_size:0] AF_V    = AF_LVL[mem_size:0];
  localparam logic [mem_size:0] AE_V    = AE_LVL[mem_size:0];

  logic [mem_size-1:0] wr_ptr;
  logic [mem_size-1:0] rd_ptr;
  logic [mem_size:0]   count_q;
  logic                acc_w;
  logic                acc_r;

  // Status flags depend only on the registered count.
  // This keeps push and pop out of the flag timing path.
  assign full         = (count_q == DEPTH_V);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_V);
  assign almost_empty = (count_q <= AE_V);
  assign count        = count_q;

  // Accepted accesses use the start-of-cycle full/empty flags.
  // Gating with rst keeps the RAM strobes quiet while reset is held.
  assign acc_w = rst & push & ~full  & ~flush;
  assign acc_r = rst & pop  & ~empty & ~flush;

  assign mem_we       = acc_w;
  assign mem_we_point = wr_ptr;
  assign mem_re       = acc_r;
  assign mem_re_point = rd_ptr;

  // Pointers advance on each accepted access and wrap naturally at 2**mem_size.
  // Flush returns both pointers to the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (acc_w) wr_ptr <= wr_ptr + 1'b1;
      if (acc_r) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy count. A simultaneous accepted push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case ({acc_w, acc_r})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The RAM read has one cycle of latency, so rvalid is last cycle's accepted pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= acc_r;
    end
  end

  // Sticky error flags. A clear wins over a set in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full  & ~flush) overflow  <= 1'b1;
      if (pop  & empty & ~flush) underflow <= 1'b1;
    end
  end

endmodule
